reg_file_2r1w: RTL and testbench

Two-read, one-write 32 x 32-bit general-purpose register file for the DaVinci datapath. It sits directly upstream of the 32-bit operand muxes and ALU. It stores the architectural registers and presents two registered read operands per cycle, selected by 5-bit register addresses through a 32:1 word-select tree. Write-back data arrives on a single write port from the stage that chooses between ALU result and memory data.

---
 rtl/davinci_pkg.sv | 13 +
 rtl/reg_file_2r1w_if.sv | 28 ++
 rtl/reg32_ld.sv | 22 ++
 rtl/reg_file_2r1w.sv | 68 ++++++
 tb/tb_reg_file_2r1w.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/davinci_pkg.sv
// Shared DaVinci datapath constants and the register-index type used by
// write decode and forwarding logic.
package davinci_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;

  localparam logic [DATA_WIDTH-1:0] REG_RESET_VALUE = 32'h0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Port bundle for the 2-read/1-write register file.
// Optional feature macro affecting this bundle's slave: REGFILE_WRITE_BYPASS_EN.
import davinci_pkg::*;

interface reg_file_2r1w_if;
  // READ and WRITE are plain per-cycle strobes with no back-pressure:
  // whatever is presented at a rising edge with the strobe high is taken
  // at that edge, and DATA_R1/DATA_R2 are valid from the following cycle.
  logic                  READ;
  logic                  WRITE;
  reg_idx_t              ADDR_R1;
  reg_idx_t              ADDR_R2;
  reg_idx_t              ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;

  modport master (
    output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    input  DATA_R1, DATA_R2
  );

  modport slave (
    input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    output DATA_R1, DATA_R2
  );

endinterface

// File: rtl/reg32_ld.sv
// Word register with load enable and asynchronous active-low clear.
import davinci_pkg::*;

module reg32_ld #(
  parameter int W = DATA_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= REG_RESET_VALUE[W-1:0];
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x 32-bit register file, two registered read ports and one write port.
// Define REGFILE_WRITE_BYPASS_EN for write-first same-cycle reads; default is read-first.
import davinci_pkg::*;

module reg_file_2r1w (
  input  logic             CLK,
  input  logic             RST,
  reg_file_2r1w_if.slave   bus
);

  logic [DATA_WIDTH-1:0] reg_q [1:REG_COUNT-1];
  logic [DATA_WIDTH-1:0] words [0:REG_COUNT-1];
  logic [REG_COUNT-1:1]  wen;
  logic [DATA_WIDTH-1:0] rd1_next;
  logic [DATA_WIDTH-1:0] rd2_next;

  // R0 has no storage; R1..R31 each get a one-hot write enable.
  for (genvar i = 1; i < REG_COUNT; i++) begin : g_regs
    assign wen[i] = bus.WRITE && (bus.ADDR_W == reg_idx_t'(i));

    reg32_ld #(.W(DATA_WIDTH)) u_reg (
      .CLK (CLK),
      .RST (RST),
      .ld  (wen[i]),
      .d   (bus.DATA_W),
      .q   (reg_q[i])
    );
  end

  // Word-select tree input: index 0 is hard zero.
  always_comb begin
    words[0] = REG_RESET_VALUE;
    for (int i = 1; i < REG_COUNT; i++) begin
      words[i] = reg_q[i];
    end
  end

  always_comb begin
    rd1_next = words[bus.ADDR_R1];
    rd2_next = words[bus.ADDR_R2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward write data on an address match; R0 never forwards.
    if (bus.WRITE && (bus.ADDR_W != '0) && (bus.ADDR_W == bus.ADDR_R1)) begin
      rd1_next = bus.DATA_W;
    end
    if (bus.WRITE && (bus.ADDR_W != '0) && (bus.ADDR_W == bus.ADDR_R2)) begin
      rd2_next = bus.DATA_W;
    end
`endif
  end

  reg32_ld #(.W(DATA_WIDTH)) u_out_r1 (
    .CLK (CLK),
    .RST (RST),
    .ld  (bus.READ),
    .d   (rd1_next),
    .q   (bus.DATA_R1)
  );

  reg32_ld #(.W(DATA_WIDTH)) u_out_r2 (
    .CLK (CLK),
    .RST (RST),
    .ld  (bus.READ),
    .d   (rd2_next),
    .q   (bus.DATA_R2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed plus random bench for reg_file_2r1w against an array-based model.
// Follows REGFILE_WRITE_BYPASS_EN the same way the design build does.
module tb_reg_file_2r1w;

  logic CLK;
  logic RST;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers and expected outputs.
  logic [31:0] mem [0:31];
  logic [31:0] exp_r1;
  logic [31:0] exp_r2;

  reg_file_2r1w_if bus ();

  reg_file_2r1w dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic wr,
                                             input logic [4:0] aw, input logic [31:0] dw);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr && aw == a) return dw;
`endif
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    exp_r1 = 32'h0;
    exp_r2 = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Driver: present one cycle of stimulus at a negedge, update the model at
  // the rising edge, compare outputs at the following negedge.
  task automatic step(input logic rd, input logic wr, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
    bus.READ    = rd;
    bus.WRITE   = wr;
    bus.ADDR_R1 = a1;
    bus.ADDR_R2 = a2;
    bus.ADDR_W  = aw;
    bus.DATA_W  = dw;
    @(posedge CLK);
    if (rd) begin
      exp_r1 = model_read(a1, wr, aw, dw);
      exp_r2 = model_read(a2, wr, aw, dw);
    end
    if (wr && aw != 5'd0) mem[aw] = dw;
    @(negedge CLK);
    check("model_r1", bus.DATA_R1, exp_r1);
    check("model_r2", bus.DATA_R2, exp_r2);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  initial begin
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    bus.ADDR_R1 = '0; bus.ADDR_R2 = '0; bus.ADDR_W = '0; bus.DATA_W = '0;
    model_clear();
    RST = 1'b0;
    #12;
    check("reset_r1", bus.DATA_R1, 32'h0);
    check("reset_r2", bus.DATA_R2, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // Basic write then read
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
    check("basic_r1", bus.DATA_R1, 32'hDEADBEEF);
    check("basic_r2", bus.DATA_R2, 32'h0);

    // R0 protection
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    check("r0_r1", bus.DATA_R1, 32'h0);
    check("r0_r2", bus.DATA_R2, 32'h0);
    // R0 read during a same-cycle write to R0
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    check("r0_wr_r1", bus.DATA_R1, 32'h0);

    // Same-cycle read/write conflict on R3, port 1 only; port 2 reads R7
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h11111111);
    step(1'b1, 1'b1, 5'd3, 5'd7, 5'd3, 32'h22222222);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("conflict_r1", bus.DATA_R1, 32'h22222222);
`else
    check("conflict_r1", bus.DATA_R1, 32'h11111111);
`endif
    check("conflict_r2", bus.DATA_R2, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
    check("conflict_next", bus.DATA_R1, 32'h22222222);

    // Hold while READ is low
    step(1'b1, 1'b0, 5'd7, 5'd3, 5'd0, 32'h0);
    check("hold_load", bus.DATA_R1, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd9, 5'd1, 5'd7, 32'h0);
    step(1'b0, 1'b0, 5'd2, 5'd4, 5'd0, 32'h0);
    check("hold_r1", bus.DATA_R1, 32'hDEADBEEF);
    check("hold_r2", bus.DATA_R2, 32'h22222222);
    step(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
    check("hold_release", bus.DATA_R1, 32'h0);

    // Full sweep
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'hA5A50000 + i);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      check("sweep_r1", bus.DATA_R1, (i == 0) ? 32'h0 : 32'hA5A50000 + i);
      check("sweep_r2", bus.DATA_R2, (i == 31) ? 32'h0 : 32'hA5A50000 + (31 - i));
    end

    // Random traffic, model-checked every cycle
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), $urandom);
    end

    // Asynchronous reset mid-cycle after prior writes
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hCAFEF00D);
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd31, 32'hBEEFCAFE);
    check("pre_rst_r1", bus.DATA_R1, model_read(5'd5, 1'b0, 5'd0, 32'h0));
    bus.WRITE = 1'b1; bus.ADDR_W = 5'd5; bus.DATA_W = 32'h77777777;
    #2 RST = 1'b0;
    #1;
    check("async_rst_r1", bus.DATA_R1, 32'h0);
    check("async_rst_r2", bus.DATA_R2, 32'h0);
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    check("rst_held_r1", bus.DATA_R1, 32'h0);
    bus.WRITE = 1'b0;
    RST = 1'b1;
    step(1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
    check("post_rst_r5", bus.DATA_R1, 32'h0);
    check("post_rst_r31", bus.DATA_R2, 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
